// File: rtl/gray_convert.sv
`default_nettype none
// ============================================================================
// Module      : gray_convert
// Description : Converts a byte-serial RGB camera stream (R, G, B per pixel)
//               into one 8-bit luma byte per pixel with a one-cycle strobe.
//               Counts pixels per frame, pulses GS_done after the last pixel
//               and flags frame-sync errors (sticky until the frame ends).
// Ports       :
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   GS_enable  in   1  controller enable; low aborts the current frame
//   cam_valid  in   1  cam_data valid this cycle
//   cam_sof    in   1  start of frame, marks the R byte of pixel 0
//   cam_data   in   8  camera byte (R, G or B)
//   data_out   out  8  gray byte, holds between strobes
//   GS_valid   out  1  one-cycle strobe, data_out valid
//   GS_done    out  1  one-cycle pulse with the last pixel of a frame
//   GS_err     out  1  sticky frame-sync error flag
// Revision    : 1.0  initial release
// ============================================================================
module gray_convert #(
  parameter int N = 480,
  parameter int M = 320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       GS_enable,
  input  logic       cam_valid,
  input  logic       cam_sof,
  input  logic [7:0] cam_data,
  output logic [7:0] data_out,
  output logic       GS_valid,
  output logic       GS_done,
  output logic       GS_err
);

  localparam int CNT_W = (N * M > 1) ? $clog2(N * M) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N * M - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       r_q, r_d;
  logic [7:0]       g_q, g_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Weights sum to 256, so the weighted sum never exceeds 65280 and the
  // gray value is simply the upper byte of the lower 16 bits.
  logic [16:0] w_sum;
  assign w_sum = 17'd77  * {9'd0, r_q}
               + 17'd150 * {9'd0, g_q}
               + 17'd29  * {9'd0, cam_data};

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    r_d     = r_q;
    g_d     = g_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        phase_d = 2'd0;
        count_d = '0;
        if (GS_enable && cam_valid && cam_sof) begin
          r_d     = cam_data;
          phase_d = 2'd1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (!GS_enable) begin
          // Abort: partial pixel and count are dropped.
          state_d = S_IDLE;
          phase_d = 2'd0;
          count_d = '0;
          err_d   = 1'b0;
        end else if (cam_valid) begin
          if (cam_sof) begin
            // Any SOF other than at the very first byte of the frame is a
            // resync: flag it and restart the frame on this byte.
            if (!(phase_q == 2'd0 && count_q == '0)) begin
              err_d = 1'b1;
            end
            r_d     = cam_data;
            phase_d = 2'd1;
            count_d = '0;
          end else begin
            case (phase_q)
              2'd0: begin
                r_d     = cam_data;
                phase_d = 2'd1;
              end
              2'd1: begin
                g_d     = cam_data;
                phase_d = 2'd2;
              end
              2'd2: begin
                data_d  = 8'(w_sum >> 8);
                valid_d = 1'b1;
                phase_d = 2'd0;
                if (count_q == LAST_PIX) begin
                  count_d = '0;
                  state_d = S_DONE;
                  done_d  = 1'b1;
                end else begin
                  count_d = count_q + CNT_W'(1);
                end
              end
              default: phase_d = 2'd0;
            endcase
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 2'd0;
      count_q <= '0;
      r_q     <= 8'h00;
      g_q     <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
      r_q     <= r_d;
      g_q     <= g_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign data_out = data_q;
  assign GS_valid = valid_q;
  assign GS_done  = done_q;
  assign GS_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_convert.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_convert
// Description : Directed self-checking bench for gray_convert (N=2, M=2).
// Revision    : 1.0  initial release
// ============================================================================
module tb_gray_convert;

  logic       clk;
  logic       rst;
  logic       GS_enable;
  logic       cam_valid;
  logic       cam_sof;
  logic [7:0] cam_data;
  logic [7:0] data_out;
  logic       GS_valid;
  logic       GS_done;
  logic       GS_err;

  int n_checks;
  int n_fail;
  int cycle;
  int strobes;
  int dones;

  logic [7:0] pr  [4];
  logic [7:0] pg  [4];
  logic [7:0] pb  [4];
  logic [7:0] exp_y [4];

  gray_convert #(.N(2), .M(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .GS_enable (GS_enable),
    .cam_valid (cam_valid),
    .cam_sof   (cam_sof),
    .cam_data  (cam_data),
    .data_out  (data_out),
    .GS_valid  (GS_valid),
    .GS_done   (GS_done),
    .GS_err    (GS_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Strobes are one cycle wide, so each is seen at exactly one falling edge.
  always @(negedge clk) begin
    if (GS_valid) strobes <= strobes + 1;
    if (GS_done)  dones   <= dones + 1;
  end

  // Present one byte (or idle) for one clock, then sample 1 time unit later.
  task automatic cyc(input logic v, input logic s, input logic [7:0] d);
    cam_valid = v;
    cam_sof   = s;
    cam_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Sends the 4-pixel test frame. gap idle cycles are inserted between G and
  // B of pixel 1; r0_sent skips pixel 0's R byte (already sent by caller).
  task automatic send_frame(input int gap, input bit r0_sent, input logic err_at_done);
    int t1;
    int t2;
    int s0;
    t1 = 0;
    t2 = 0;
    s0 = strobes;
    for (int p = 0; p < 4; p++) begin
      if (!(p == 0 && r0_sent)) cyc(1'b1, p == 0, pr[p]);
      cyc(1'b1, 1'b0, pg[p]);
      if (p == 1) repeat (gap) cyc(1'b0, 1'b0, 8'h5A);
      cyc(1'b1, 1'b0, pb[p]);
      n_checks++;
      if (GS_valid !== 1'b1 || data_out !== exp_y[p]) begin
        n_fail++;
        $display("FAIL pixel%0d: valid=%b data=%0d, required valid=1 data=%0d",
                 p, GS_valid, data_out, exp_y[p]);
      end
      n_checks++;
      if (GS_done !== (p == 3)) begin
        n_fail++;
        $display("FAIL done_pixel%0d: GS_done=%b, required %b", p, GS_done, (p == 3));
      end
      if (p == 0) t1 = cycle;
      if (p == 1) t2 = cycle;
      if (p == 3) begin
        n_checks++;
        if (GS_err !== err_at_done) begin
          n_fail++;
          $display("FAIL err_at_done: GS_err=%b, required %b", GS_err, err_at_done);
        end
      end
    end
    cyc(1'b0, 1'b0, 8'h00);
    n_checks++;
    if (GS_valid !== 1'b0 || GS_done !== 1'b0 || GS_err !== 1'b0) begin
      n_fail++;
      $display("FAIL after_frame: valid=%b done=%b err=%b, required 0 0 0",
               GS_valid, GS_done, GS_err);
    end
    n_checks++;
    if (t2 - t1 != 3 + gap) begin
      n_fail++;
      $display("FAIL strobe_spacing: %0d cycles, required %0d", t2 - t1, 3 + gap);
    end
    n_checks++;
    if (strobes - s0 != 4) begin
      n_fail++;
      $display("FAIL strobe_count: %0d strobes, required 4", strobes - s0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 8'h00 || GS_valid !== 1'b0 || GS_done !== 1'b0 || GS_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: data=%0d valid=%b done=%b err=%b, required all 0",
               data_out, GS_valid, GS_done, GS_err);
    end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_frame();
    send_frame(0, 1'b0, 1'b0);
  endtask

  task automatic test_gap();
    send_frame(5, 1'b0, 1'b0);
  endtask

  task automatic test_idle_nosof();
    int s0;
    s0 = strobes;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'(8'hF0 + i));
    cyc(1'b0, 1'b0, 8'h00);
    n_checks++;
    if (strobes != s0) begin
      n_fail++;
      $display("FAIL idle_nosof: %0d strobes, required 0", strobes - s0);
    end
    send_frame(0, 1'b0, 1'b0);
  endtask

  task automatic test_sof_err();
    int s0;
    int d0;
    s0 = strobes;
    d0 = dones;
    cyc(1'b1, 1'b1, 8'd100);
    cyc(1'b1, 1'b0, 8'd50);
    cyc(1'b1, 1'b0, 8'd200);
    // 77*100 + 150*50 + 29*200 = 21000 -> 82
    n_checks++;
    if (GS_valid !== 1'b1 || data_out !== 8'd82) begin
      n_fail++;
      $display("FAIL pre_err_pixel: valid=%b data=%0d, required valid=1 data=82",
               GS_valid, data_out);
    end
    cyc(1'b1, 1'b0, 8'd10);
    n_checks++;
    if (GS_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_early: GS_err=%b, required 0", GS_err);
    end
    // SOF on pixel 1's G byte: becomes R (255) of a fresh pixel 0.
    cyc(1'b1, 1'b1, pr[0]);
    n_checks++;
    if (GS_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: GS_err=%b, required 1", GS_err);
    end
    send_frame(0, 1'b1, 1'b1);
    n_checks++;
    if (strobes - s0 != 5 || dones - d0 != 1) begin
      n_fail++;
      $display("FAIL sof_err_totals: strobes=%0d dones=%0d, required 5 and 1",
               strobes - s0, dones - d0);
    end
  endtask

  task automatic test_enable_drop();
    int s0;
    int d0;
    s0 = strobes;
    d0 = dones;
    cyc(1'b1, 1'b1, pr[0]);
    cyc(1'b1, 1'b0, pg[0]);
    cyc(1'b1, 1'b0, pb[0]);
    cyc(1'b1, 1'b0, pr[1]);
    cyc(1'b1, 1'b0, pg[1]);
    GS_enable = 1'b0;
    cyc(1'b1, 1'b0, pb[1]);
    for (int p = 2; p < 4; p++) begin
      cyc(1'b1, 1'b0, pr[p]);
      cyc(1'b1, 1'b0, pg[p]);
      cyc(1'b1, 1'b0, pb[p]);
    end
    cyc(1'b0, 1'b0, 8'h00);
    n_checks++;
    if (strobes - s0 != 1 || dones != d0) begin
      n_fail++;
      $display("FAIL enable_drop: strobes=%0d dones=%0d, required 1 and 0",
               strobes - s0, dones - d0);
    end
    GS_enable = 1'b1;
    send_frame(0, 1'b0, 1'b0);
  endtask

  task automatic test_rst_midframe();
    cyc(1'b1, 1'b1, 8'd1);
    cyc(1'b1, 1'b1, pr[0]);
    cyc(1'b1, 1'b0, pg[0]);
    cyc(1'b1, 1'b0, pb[0]);
    n_checks++;
    if (GS_valid !== 1'b1 || data_out !== 8'd255 || GS_err !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst: valid=%b data=%0d err=%b, required 1 255 1",
               GS_valid, data_out, GS_err);
    end
    cyc(1'b1, 1'b0, pr[1]);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (data_out !== 8'h00 || GS_valid !== 1'b0 || GS_done !== 1'b0 || GS_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: data=%0d valid=%b done=%b err=%b, required all 0",
               data_out, GS_valid, GS_done, GS_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cycle     = 0;
    strobes   = 0;
    dones     = 0;
    rst       = 1'b1;
    GS_enable = 1'b1;
    cam_valid = 1'b0;
    cam_sof   = 1'b0;
    cam_data  = 8'h00;

    pr[0] = 8'd255; pg[0] = 8'd255; pb[0] = 8'd255; exp_y[0] = 8'd255;
    pr[1] = 8'd255; pg[1] = 8'd0;   pb[1] = 8'd0;   exp_y[1] = 8'd76;
    pr[2] = 8'd0;   pg[2] = 8'd255; pb[2] = 8'd0;   exp_y[2] = 8'd149;
    pr[3] = 8'd0;   pg[3] = 8'd0;   pb[3] = 8'd255; exp_y[3] = 8'd28;

    test_reset();
    test_frame();
    test_gap();
    test_idle_nosof();
    test_sof_err();
    test_enable_drop();
    test_rst_midframe();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
